// File: rtl/ahb_lite_pkg.sv
// AHB-Lite encodings and burst helpers shared by the master bridge.
// Pure declarations and functions; no state, no latency.
// No flow control of its own.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_INCR4  = 3'b011,
    HBURST_INCR8  = 3'b101,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DRAIN,
    ST_REJECT
  } bridge_state_e;

  // Number of bus beats for a cmd_len code
  function automatic logic [4:0] len_to_beats(input logic [1:0] len);
    case (len)
      2'd0:    return 5'd1;
      2'd1:    return 5'd4;
      2'd2:    return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  // HBURST encoding for a cmd_len code
  function automatic logic [2:0] len_to_hburst(input logic [1:0] len);
    case (len)
      2'd0:    return HBURST_SINGLE;
      2'd1:    return HBURST_INCR4;
      2'd2:    return HBURST_INCR8;
      default: return HBURST_INCR16;
    endcase
  endfunction

  // Copy an LSB-justified beat onto every lane it could occupy
  function automatic logic [31:0] replicate_wdata(input logic [31:0] d, input logic [1:0] size);
    case (size)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_master_bridge_if.sv
// AHB-Lite bus bundle between one master and the slave fabric.
// Wires only; no latency.
// HREADY from the slave side stalls the master.
interface ahb_lite_master_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [1:0]            HTRANS;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_master_bridge_addr_gen.sv
// Burst address/beat tracking plus legality check of an offered command.
// Check is combinational; address and beat update one cycle after load/step.
// Advances only on step, so bus stalls simply hold it.
module ahb_burst_addr_gen
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic                  step,
  input  logic [1:0]            size,
  input  logic [9:0]            chk_addr,
  input  logic [1:0]            chk_size,
  input  logic [1:0]            chk_len,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [3:0]            beat,
  output logic                  chk_bad
);

  logic        misaligned;
  logic [11:0] span_end;

  // Offered command is illegal for size 3, misalignment, or running past its 1KB window
  always_comb begin
    misaligned = ((chk_size == 2'd1) && chk_addr[0]) ||
                 ((chk_size == 2'd2) && (chk_addr[1:0] != 2'b00));
    span_end   = {2'b00, chk_addr} + (12'(len_to_beats(chk_len)) << chk_size);
    chk_bad    = (chk_size == 2'd3) || misaligned || (span_end > 12'h400);
  end

  // Reload on a new command, advance address and beat index per accepted beat
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr <= '0;
      beat <= '0;
    end else if (load) begin
      addr <= start_addr;
      beat <= '0;
    end else if (step) begin
      addr <= addr + (ADDR_WIDTH'(1) << size);
      beat <= beat + 4'd1;
    end
  end

endmodule

// File: rtl/ahb_lite_master_bridge.sv
// Command/write-data stream to AHB-Lite SINGLE/INCR4/8/16 master, one response per beat.
// First address phase the cycle after cmd accept; response one cycle after each data phase.
// HREADY low freezes the bus; missing write data mid-burst shows BUSY; rsp has no backpressure.
module ahb_lite_master_bridge
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_size,
  input  logic [1:0]            cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  rsp_last,
  ahb_lite_master_bridge_if.master bus
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("ahb_lite_master_bridge: only DATA_WIDTH=32 is supported");
  end

  bridge_state_e         state_q, state_d;
  htrans_e               htrans;
  logic                  wr_q, hold_q, present, accept, load, chk_bad;
  logic [1:0]            size_q, len_q;
  logic [3:0]            beat, last_idx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wbuf_q, hwdata_q;
  logic                  dp_vld_q, dp_last_q, dp_write_q;

  assign load     = (state_q == ST_IDLE) && cmd_valid && !chk_bad;
  assign last_idx = 4'(len_to_beats(len_q) - 5'd1);

  ahb_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .load       (load),
    .start_addr (cmd_addr),
    .step       (accept),
    .size       (size_q),
    .chk_addr   (cmd_addr[9:0]),
    .chk_size   (cmd_size),
    .chk_len    (cmd_len),
    .addr       (addr),
    .beat       (beat),
    .chk_bad    (chk_bad)
  );

  assign bus.HADDR  = addr;
  assign bus.HWRITE = wr_q;
  assign bus.HSIZE  = {1'b0, size_q};
  assign bus.HBURST = len_to_hburst(len_q);
  assign bus.HTRANS = htrans;
  assign bus.HWDATA = hwdata_q;

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and handshake/transfer-type decode; a beat held by a wait state stays presented
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    wdata_ready = 1'b0;
    present     = 1'b0;
    accept      = 1'b0;
    htrans      = HTRANS_IDLE;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = chk_bad ? ST_REJECT : ST_ADDR;
      end
      ST_ADDR: begin
        present     = !wr_q || wdata_valid || hold_q;
        accept      = present && bus.HREADY;
        wdata_ready = wr_q && wdata_valid && !hold_q;
        if (present) begin
          if (beat == 4'd0) htrans = HTRANS_NONSEQ;
          else              htrans = HTRANS_SEQ;
        end else begin
          if (beat == 4'd0) htrans = HTRANS_IDLE;
          else              htrans = HTRANS_BUSY;
        end
        if (accept && (beat == last_idx)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.HREADY) state_d = ST_IDLE;
      end
      ST_REJECT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Command attributes latched at acceptance, constant for the whole burst
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q   <= 1'b0;
      size_q <= 2'd0;
      len_q  <= 2'd0;
    end else if (load) begin
      wr_q   <= cmd_write;
      size_q <= cmd_size;
      len_q  <= cmd_len;
    end
  end

  // Write beat capture; HWDATA only changes when its address phase is accepted
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_q   <= 1'b0;
      wbuf_q   <= '0;
      hwdata_q <= '0;
    end else begin
      hold_q <= present && !bus.HREADY;
      if (wdata_ready) wbuf_q <= wdata;
      if (accept && wr_q) hwdata_q <= replicate_wdata(hold_q ? wbuf_q : wdata, size_q);
    end
  end

  // Data-phase tracker, moves only on HREADY
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_vld_q   <= 1'b0;
      dp_last_q  <= 1'b0;
      dp_write_q <= 1'b0;
    end else if (bus.HREADY) begin
      dp_vld_q   <= accept;
      dp_last_q  <= accept && (beat == last_idx);
      dp_write_q <= wr_q;
    end
  end

  // Response beat: rejection at acceptance, or completion of a data phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_last  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_last  <= 1'b0;
      if ((state_q == ST_IDLE) && cmd_valid && chk_bad) begin
        rsp_valid <= 1'b1;
        rsp_data  <= '0;
        rsp_err   <= 1'b1;
        rsp_last  <= 1'b1;
      end else if (dp_vld_q && bus.HREADY) begin
        rsp_valid <= 1'b1;
        rsp_data  <= dp_write_q ? '0 : bus.HRDATA;
        rsp_err   <= bus.HRESP;
        rsp_last  <= dp_last_q;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Bridge driving a 64KB lane-decoding memory slave; responses checked by a scoreboard.
// Expected beats are queued at command issue and popped by an independent monitor.
// Slave HREADY and a one-address HRESP error are steered from the stimulus.
module tb_ahb_lite_master_bridge;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        last;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [1:0]  cmd_size = '0, cmd_len = '0;
  logic        wdata_valid = 1'b0;
  logic [31:0] wdata = '0;
  logic        cmd_ready, wdata_ready, rsp_valid, rsp_err, rsp_last;
  logic [31:0] rsp_data;
  logic        hready = 1'b1;
  logic [15:0] err_addr = 16'hFFFF;
  logic        sb_ignore = 1'b0;

  int          total = 0;
  int          bad = 0;
  rsp_t        sb_q[$];
  logic [17:0] alog[$];
  logic [31:0] wlog[$];
  logic [31:0] wbeats[16];

  logic [7:0]  mem[65536];
  logic        s_act, s_wr;
  logic [15:0] s_addr;
  logic [1:0]  s_size;

  always #5 clk = ~clk;

  ahb_lite_master_bridge_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  ahb_lite_master_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .HCLK(clk), .HRESETn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_last(rsp_last),
    .bus(bus.master)
  );

  // Memory slave: zero-wait unless the bench pulls HREADY, little-endian lanes
  assign bus.HREADY = hready;
  assign bus.HRESP  = s_act && (s_addr == err_addr);
  assign bus.HRDATA = {mem[{s_addr[15:2], 2'b11}], mem[{s_addr[15:2], 2'b10}],
                       mem[{s_addr[15:2], 2'b01}], mem[{s_addr[15:2], 2'b00}]};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_act <= 1'b0; s_wr <= 1'b0; s_addr <= '0; s_size <= '0;
    end else if (hready) begin
      if (s_act && s_wr)
        for (int i = 0; i < 4; i++)
          if (i < (1 << s_size))
            mem[s_addr + 16'(i)] <= bus.HWDATA[8*((int'(s_addr[1:0]) + i) % 4) +: 8];
      s_act  <= bus.HTRANS[1];
      s_wr   <= bus.HWRITE;
      s_addr <= bus.HADDR;
      s_size <= bus.HSIZE[1:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid && !sb_ignore) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_unexpected: got data=%h err=%b last=%b want no response", rsp_data, rsp_err, rsp_last);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_last", 32'(rsp_last), 32'(e.last));
      end
    end
  end

  // Bus logs: accepted address phases and completed write data phases
  always @(negedge clk) begin
    if (rst_n && hready && bus.HTRANS[1]) alog.push_back({bus.HTRANS, bus.HADDR});
    if (rst_n && hready && s_act && s_wr) wlog.push_back(bus.HWDATA);
  end

  task automatic push_exp(input logic [31:0] d, input logic e, input logic l);
    rsp_t r;
    r = {d, e, l};
    sb_q.push_back(r);
  endtask

  task automatic push_wr(input int n);
    for (int i = 0; i < n; i++) push_exp(32'h0, 1'b0, i == n - 1);
  endtask

  task automatic do_cmd(input logic wr, input logic [15:0] a, input logic [1:0] sz, input logic [1:0] ln);
    int n;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_len = ln;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 100);
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b want 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_wbeats(input int n, input int gap_before, input int gap_cycles, input logic [15:0] busy_addr);
    int t;
    for (int b = 0; b < n; b++) begin
      if (b == gap_before) begin
        wdata_valid = 1'b0;
        for (int g = 0; g < gap_cycles; g++) begin
          @(negedge clk);
          chk("busy_htrans", 32'(bus.HTRANS), 32'h1);
          chk("busy_haddr", 32'(bus.HADDR), 32'(busy_addr));
          @(posedge clk); #1;
        end
      end
      wdata_valid = 1'b1; wdata = wbeats[b];
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!wdata_ready && t < 100);
      if (!wdata_ready) begin
        total++; bad++;
        $display("FAIL wdata_timeout: wdata_ready=%b want 1", wdata_ready);
      end
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending=%0d want 0", sb_q.size());
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_htrans", 32'(bus.HTRANS), 32'h0);
    chk("rst_haddr", 32'(bus.HADDR), 32'h0);
    chk("rst_hwrite", 32'(bus.HWRITE), 32'h0);
    chk("rst_hsize", 32'(bus.HSIZE), 32'h0);
    chk("rst_hburst", 32'(bus.HBURST), 32'h0);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_wdata_ready", 32'(wdata_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_last", 32'(rsp_last), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: SINGLE word write then read
    push_wr(1);
    wbeats[0] = 32'hDEADBEEF;
    do_cmd(1'b1, 16'h0010, 2'd2, 2'd0);
    send_wbeats(1, -1, 0, 16'h0);
    wait_drain();
    push_exp(32'hDEADBEEF, 1'b0, 1'b1);
    do_cmd(1'b0, 16'h0010, 2'd2, 2'd0);
    wait_drain();

    // 2: INCR4 write 1..4, INCR4 read with an error on beat 1
    push_wr(4);
    for (int i = 0; i < 4; i++) wbeats[i] = 32'(i + 1);
    do_cmd(1'b1, 16'h0100, 2'd2, 2'd1);
    send_wbeats(4, -1, 0, 16'h0);
    wait_drain();
    alog.delete();
    err_addr = 16'h0104;
    push_exp(32'd1, 1'b0, 1'b0); push_exp(32'd2, 1'b1, 1'b0);
    push_exp(32'd3, 1'b0, 1'b0); push_exp(32'd4, 1'b0, 1'b1);
    do_cmd(1'b0, 16'h0100, 2'd2, 2'd1);
    @(negedge clk);
    chk("incr4_hburst", 32'(bus.HBURST), 32'h3);
    @(posedge clk); #1;
    wait_drain();
    err_addr = 16'hFFFF;
    chk("incr4_nbeats", 32'(alog.size()), 32'd4);
    if (alog.size() == 4) begin
      chk("incr4_beat0", 32'(alog[0]), 32'h2_0100);
      chk("incr4_beat1", 32'(alog[1]), 32'h3_0104);
      chk("incr4_beat2", 32'(alog[2]), 32'h3_0108);
      chk("incr4_beat3", 32'(alog[3]), 32'h3_010C);
    end

    // 3: INCR8 write with write data absent for 2 cycles, then read back
    push_wr(8);
    for (int i = 0; i < 8; i++) wbeats[i] = 32'h3000_0000 + 32'(i);
    do_cmd(1'b1, 16'h0200, 2'd2, 2'd2);
    send_wbeats(8, 3, 2, 16'h020C);
    wait_drain();
    for (int i = 0; i < 8; i++) push_exp(32'h3000_0000 + 32'(i), 1'b0, i == 7);
    do_cmd(1'b0, 16'h0200, 2'd2, 2'd2);
    wait_drain();

    // 4: three wait states on beat 2 of an INCR4 read
    for (int i = 0; i < 4; i++) push_exp(32'(i + 1), 1'b0, i == 3);
    do_cmd(1'b0, 16'h0100, 2'd2, 2'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.HTRANS == 2'b11 && bus.HADDR == 16'h0108) && n < 50);
    chk("stall_trigger", 32'(bus.HADDR), 32'h0108);
    @(posedge clk); #1 hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_haddr", 32'(bus.HADDR), 32'h010C);
      chk("stall_htrans", 32'(bus.HTRANS), 32'h3);
      @(posedge clk); #1;
    end
    hready = 1'b1;
    wait_drain();

    // 5: rejected commands never touch the bus
    alog.delete();
    push_exp(32'h0, 1'b1, 1'b1);
    do_cmd(1'b0, 16'h0000, 2'd3, 2'd0);
    @(negedge clk);
    chk("reject_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("reject_htrans", 32'(bus.HTRANS), 32'h0);
    wait_drain();
    push_exp(32'h0, 1'b1, 1'b1);
    do_cmd(1'b1, 16'h0001, 2'd1, 2'd0);
    wait_drain();
    push_exp(32'h0, 1'b1, 1'b1);
    do_cmd(1'b0, 16'h03F8, 2'd2, 2'd3);
    wait_drain();
    chk("reject_no_bus", 32'(alog.size()), 32'd0);

    // 6: byte write lands in lane 3; then reset in the middle of an INCR8
    push_wr(1);
    wbeats[0] = 32'h0;
    do_cmd(1'b1, 16'h0000, 2'd2, 2'd0);
    send_wbeats(1, -1, 0, 16'h0);
    wait_drain();
    wlog.delete();
    push_wr(1);
    wbeats[0] = 32'h0000_00A5;
    do_cmd(1'b1, 16'h0003, 2'd0, 2'd0);
    send_wbeats(1, -1, 0, 16'h0);
    wait_drain();
    chk("byte_hwdata_count", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) chk("byte_hwdata", wlog[0], 32'hA5A5A5A5);
    push_exp(32'hA500_0000, 1'b0, 1'b1);
    do_cmd(1'b0, 16'h0000, 2'd2, 2'd0);
    wait_drain();

    sb_ignore = 1'b1;
    do_cmd(1'b0, 16'h0100, 2'd2, 2'd2);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_htrans", 32'(bus.HTRANS), 32'h0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    sb_ignore = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_htrans", 32'(bus.HTRANS), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
